// File: rtl/writeback_stage_if.sv
// Handshake and data bus of the writeback stage: upstream instruction, memory
// read response, flush, and the register-file write port.
interface writeback_stage_if #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5,
  parameter int OFF_W      = $clog2(XLEN / 8)
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [1:0]            wb_sel_i;
  logic                  rd_we_i;
  logic [REG_ADDR_W-1:0] rd_addr_i;
  logic [XLEN-1:0]       alu_result_i;
  logic [XLEN-1:0]       pc_plus4_i;
  logic [XLEN-1:0]       csr_data_i;
  logic [2:0]            load_funct3_i;
  logic [OFF_W-1:0]      load_offset_i;
  logic                  mem_rvalid_i;
  logic [XLEN-1:0]       mem_rdata_i;
  logic                  flush_i;
  logic                  rd_we_o;
  logic [REG_ADDR_W-1:0] rd_addr_o;
  logic [XLEN-1:0]       rd_data_o;
  logic                  retire_o;
  logic                  load_err_o;
  logic                  busy_o;

  modport slave (
    input  in_valid_i, wb_sel_i, rd_we_i, rd_addr_i, alu_result_i, pc_plus4_i,
           csr_data_i, load_funct3_i, load_offset_i, mem_rvalid_i, mem_rdata_i,
           flush_i,
    output in_ready_o, rd_we_o, rd_addr_o, rd_data_o, retire_o, load_err_o,
           busy_o
  );

  modport master (
    output in_valid_i, wb_sel_i, rd_we_i, rd_addr_i, alu_result_i, pc_plus4_i,
           csr_data_i, load_funct3_i, load_offset_i, mem_rvalid_i, mem_rdata_i,
           flush_i,
    input  in_ready_o, rd_we_o, rd_addr_o, rd_data_o, retire_o, load_err_o,
           busy_o
  );
endinterface

// File: rtl/writeback_stage.sv
// RISC-V writeback stage: selects MEM/ALU/PC+4/CSR results, waits for and
// aligns load data, and drives a registered regfile write port plus retire.
module writeback_stage #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5,
  parameter int OFF_W      = $clog2(XLEN / 8)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  writeback_stage_if.slave   wb
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, DRAIN} state_e;

  state_e                state_q, state_d;
  logic                  ld_we_q, ld_we_d;
  logic [REG_ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic [2:0]            ld_funct3_q, ld_funct3_d;
  logic [OFF_W-1:0]      ld_off_q, ld_off_d;
  logic                  rd_we_q, rd_we_d;
  logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]       rd_data_q, rd_data_d;
  logic                  retire_q, retire_d;
  logic                  load_err_q, load_err_d;

  logic                  accept;
  logic [XLEN-1:0]       shifted;
  logic [XLEN-1:0]       load_val;
  logic                  misaligned;
  logic                  load_bad;
  logic [XLEN-1:0]       sel_val;

  assign accept = wb.in_valid_i && (state_q == IDLE) && !wb.flush_i;

  always_comb begin
    shifted = wb.mem_rdata_i >> SHW'({ld_off_q, 3'b000});
    case (ld_funct3_q)
      3'b000:  load_val = XLEN'($signed(shifted[7:0]));
      3'b001:  load_val = XLEN'($signed(shifted[15:0]));
      3'b010:  load_val = XLEN'($signed(shifted[31:0]));
      3'b100:  load_val = XLEN'(shifted[7:0]);
      3'b101:  load_val = XLEN'(shifted[15:0]);
      3'b110:  load_val = XLEN'(shifted[31:0]);
      default: load_val = shifted;
    endcase
  end

  // Alignment is judged against the access size encoded in funct3[1:0].
  always_comb begin
    case (ld_funct3_q[1:0])
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = ld_off_q[0];
      2'd2:    misaligned = |ld_off_q[1:0];
      default: misaligned = |ld_off_q;
    endcase
    load_bad = (ld_funct3_q == 3'b111) || misaligned ||
               ((XLEN == 32) && (ld_funct3_q == 3'b011 || ld_funct3_q == 3'b110));
  end

  always_comb begin
    case (wb.wb_sel_i)
      2'd1:    sel_val = wb.alu_result_i;
      2'd2:    sel_val = wb.pc_plus4_i;
      default: sel_val = wb.csr_data_i;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    ld_we_d     = ld_we_q;
    ld_addr_d   = ld_addr_q;
    ld_funct3_d = ld_funct3_q;
    ld_off_d    = ld_off_q;
    rd_we_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_data_d   = rd_data_q;
    retire_d    = 1'b0;
    load_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (wb.wb_sel_i != 2'd0) begin
            rd_data_d = sel_val;
            rd_addr_d = wb.rd_addr_i;
            rd_we_d   = wb.rd_we_i && (wb.rd_addr_i != '0);
            retire_d  = 1'b1;
          end else begin
            ld_we_d     = wb.rd_we_i && (wb.rd_addr_i != '0);
            ld_addr_d   = wb.rd_addr_i;
            ld_funct3_d = wb.load_funct3_i;
            ld_off_d    = wb.load_offset_i;
            state_d     = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: begin
        if (wb.flush_i) begin
          // A response arriving with the flush is dropped on the spot.
          state_d = wb.mem_rvalid_i ? IDLE : DRAIN;
        end else if (wb.mem_rvalid_i) begin
          state_d   = IDLE;
          retire_d  = 1'b1;
          rd_addr_d = ld_addr_q;
          if (load_bad) begin
            load_err_d = 1'b1;
            rd_data_d  = '0;
          end else begin
            rd_we_d   = ld_we_q;
            rd_data_d = load_val;
          end
        end
      end
      DRAIN: begin
        if (wb.mem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ld_we_q     <= 1'b0;
      ld_addr_q   <= '0;
      ld_funct3_q <= '0;
      ld_off_q    <= '0;
      rd_we_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      retire_q    <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_we_q     <= ld_we_d;
      ld_addr_q   <= ld_addr_d;
      ld_funct3_q <= ld_funct3_d;
      ld_off_q    <= ld_off_d;
      rd_we_q     <= rd_we_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
      retire_q    <= retire_d;
      load_err_q  <= load_err_d;
    end
  end

  assign wb.in_ready_o = (state_q == IDLE);
  assign wb.busy_o     = (state_q != IDLE);
  assign wb.rd_we_o    = rd_we_q;
  assign wb.rd_addr_o  = rd_addr_q;
  assign wb.rd_data_o  = rd_data_q;
  assign wb.retire_o   = retire_q;
  assign wb.load_err_o = load_err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed corner cases followed by
// randomized ALU/CSR/PC and load traffic checked against a transaction model.
module tb_writeback_stage;

  localparam int XLEN = 64;
  localparam int RW   = 5;
  localparam int OW   = 3;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  logic [63:0] last_data;

  writeback_stage_if #(.XLEN(XLEN), .REG_ADDR_W(RW), .OFF_W(OW)) bus ();

  writeback_stage #(.XLEN(XLEN), .REG_ADDR_W(RW), .OFF_W(OW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .wb     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid_i    = 1'b0;
    bus.wb_sel_i      = 2'd0;
    bus.rd_we_i       = 1'b0;
    bus.rd_addr_i     = '0;
    bus.alu_result_i  = '0;
    bus.pc_plus4_i    = '0;
    bus.csr_data_i    = '0;
    bus.load_funct3_i = '0;
    bus.load_offset_i = '0;
    bus.mem_rvalid_i  = 1'b0;
    bus.mem_rdata_i   = '0;
    bus.flush_i       = 1'b0;
  endtask

  // No completion this cycle: pulses low and the data port holds its value.
  task automatic check_quiet(input string tag);
    check({tag, ".retire"}, bus.retire_o, 1'b0);
    check({tag, ".we"}, bus.rd_we_o, 1'b0);
    check({tag, ".err"}, bus.load_err_o, 1'b0);
    check({tag, ".hold"}, bus.rd_data_o, last_data);
  endtask

  // Reference load result, derived from access size and signedness.
  function automatic logic [63:0] ref_load(input logic [2:0] f3, input int off,
                                           input logic [63:0] d, output bit err);
    int nbytes;
    logic [63:0] v;
    logic [63:0] mask;
    nbytes = 1 << f3[1:0];
    err = (f3 == 3'd7) || ((off % nbytes) != 0);
    v = d >> (off * 8);
    if (nbytes < 8) begin
      mask = (64'd1 << (8 * nbytes)) - 64'd1;
      v = v & mask;
      if (!f3[2] && v[8 * nbytes - 1]) v = v | ~mask;
    end
    return err ? 64'd0 : v;
  endfunction

  task automatic do_simple(input logic [1:0] sel, input logic [4:0] rd, input logic we,
                           input logic [63:0] alu, input logic [63:0] pc, input logic [63:0] csr);
    logic [63:0] exp;
    bus.in_valid_i   = 1'b1;
    bus.wb_sel_i     = sel;
    bus.rd_we_i      = we;
    bus.rd_addr_i    = rd;
    bus.alu_result_i = alu;
    bus.pc_plus4_i   = pc;
    bus.csr_data_i   = csr;
    bus.mem_rvalid_i = 1'($urandom_range(0, 1));
    bus.mem_rdata_i  = {$urandom, $urandom};
    tick();
    exp = (sel == 2'd1) ? alu : (sel == 2'd2) ? pc : csr;
    check("simple.retire", bus.retire_o, 1'b1);
    check("simple.we", bus.rd_we_o, we && (rd != 0));
    check("simple.addr", bus.rd_addr_o, rd);
    check("simple.data", bus.rd_data_o, exp);
    check("simple.err", bus.load_err_o, 1'b0);
    check("simple.ready", bus.in_ready_o, 1'b1);
    last_data = exp;
    bus.in_valid_i   = 1'b0;
    bus.mem_rvalid_i = 1'b0;
  endtask

  // flush_at < 0: no flush; otherwise flush in that wait cycle (== delay means
  // coincident with the response).
  task automatic do_load(input logic [2:0] f3, input int off, input logic [63:0] data,
                         input logic [4:0] rd, input logic we, input int delay, input int flush_at);
    bit err;
    logic [63:0] exp;
    bit flushed;
    flushed = 0;
    bus.in_valid_i    = 1'b1;
    bus.wb_sel_i      = 2'd0;
    bus.rd_we_i       = we;
    bus.rd_addr_i     = rd;
    bus.load_funct3_i = f3;
    bus.load_offset_i = 3'(off);
    bus.alu_result_i  = {$urandom, $urandom};
    bus.mem_rvalid_i  = 1'($urandom_range(0, 1));
    bus.mem_rdata_i   = {$urandom, $urandom};
    tick();
    check_quiet("load.accept");
    check("load.busy", bus.busy_o, 1'b1);
    check("load.ready", bus.in_ready_o, 1'b0);
    for (int c = 0; c <= delay; c++) begin
      bus.in_valid_i    = 1'($urandom_range(0, 1));
      bus.wb_sel_i      = 2'($urandom_range(1, 3));
      bus.rd_addr_i     = 5'($urandom);
      bus.rd_we_i       = 1'b1;
      bus.load_funct3_i = 3'($urandom);
      bus.load_offset_i = 3'($urandom);
      bus.mem_rvalid_i  = (c == delay);
      bus.mem_rdata_i   = (c == delay) ? data : {$urandom, $urandom};
      if (flush_at >= 0 && c > flush_at) bus.flush_i = 1'($urandom_range(0, 1));
      else bus.flush_i = (c == flush_at);
      if (c == flush_at) flushed = 1;
      tick();
      if (c < delay) begin
        check_quiet("load.wait");
        check("load.wait_busy", bus.busy_o, 1'b1);
        check("load.wait_ready", bus.in_ready_o, 1'b0);
      end
    end
    idle_inputs();
    if (flushed) begin
      check_quiet("load.flushed");
    end else begin
      exp = ref_load(f3, off, data, err);
      check("load.retire", bus.retire_o, 1'b1);
      check("load.err", bus.load_err_o, err);
      check("load.we", bus.rd_we_o, we && (rd != 0) && !err);
      check("load.data", bus.rd_data_o, exp);
      if (!err) check("load.addr", bus.rd_addr_o, rd);
      last_data = exp;
    end
    check("load.done_ready", bus.in_ready_o, 1'b1);
    check("load.done_busy", bus.busy_o, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    last_data = '0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst.we", bus.rd_we_o, 1'b0);
    check("rst.addr", bus.rd_addr_o, '0);
    check("rst.data", bus.rd_data_o, '0);
    check("rst.retire", bus.retire_o, 1'b0);
    check("rst.err", bus.load_err_o, 1'b0);
    check("rst.busy", bus.busy_o, 1'b0);
    check("rst.ready", bus.in_ready_o, 1'b1);
    rst_n = 1'b1;
    tick();

    // Back-to-back ALU results, the last one to x0.
    do_simple(2'd1, 5'd5, 1'b1, 64'h11, 64'h0, 64'h0);
    do_simple(2'd1, 5'd6, 1'b1, 64'h22, 64'h0, 64'h0);
    do_simple(2'd1, 5'd0, 1'b1, 64'h33, 64'h0, 64'h0);
    tick();
    check_quiet("b2b.after");
    do_simple(2'd2, 5'd1, 1'b1, 64'h0, 64'h8000_0004, 64'h0);
    do_simple(2'd3, 5'd9, 1'b0, 64'h0, 64'h0, 64'hDEAD_BEEF_0000_0001);

    // Load alignment and extension corners.
    do_load(3'b000, 3, 64'h0000_0000_80F0_0000, 5'd7, 1'b1, 4, -1);
    do_load(3'b101, 2, 64'h0000_0000_8001_0000, 5'd8, 1'b1, 1, -1);
    do_load(3'b110, 4, 64'hFFFF_FFFF_0000_0000, 5'd9, 1'b1, 0, -1);
    do_load(3'b010, 2, 64'h1234_5678_9ABC_DEF0, 5'd10, 1'b1, 2, -1);
    do_load(3'b111, 0, 64'h1234_5678_9ABC_DEF0, 5'd11, 1'b1, 1, -1);
    do_load(3'b011, 0, 64'hFEDC_BA98_7654_3210, 5'd12, 1'b1, 0, -1);

    // Flush the cycle after an LD accept, then an immediate follow-on accept.
    do_load(3'b011, 0, 64'hCAFE_F00D_1234_5678, 5'd13, 1'b1, 3, 0);
    do_simple(2'd1, 5'd14, 1'b1, 64'h55, 64'h0, 64'h0);
    do_load(3'b001, 2, 64'h0000_0000_FFFF_0000, 5'd15, 1'b1, 2, 2);

    // A flush in IDLE suppresses acceptance.
    bus.in_valid_i   = 1'b1;
    bus.wb_sel_i     = 2'd0;
    bus.rd_addr_i    = 5'd3;
    bus.rd_we_i      = 1'b1;
    bus.flush_i      = 1'b1;
    tick();
    idle_inputs();
    check_quiet("idleflush");
    check("idleflush.busy", bus.busy_o, 1'b0);

    // Asynchronous reset while a load is outstanding.
    bus.in_valid_i    = 1'b1;
    bus.wb_sel_i      = 2'd0;
    bus.rd_addr_i     = 5'd4;
    bus.rd_we_i       = 1'b1;
    bus.load_funct3_i = 3'b011;
    tick();
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.we", bus.rd_we_o, 1'b0);
    check("arst.addr", bus.rd_addr_o, '0);
    check("arst.data", bus.rd_data_o, '0);
    check("arst.retire", bus.retire_o, 1'b0);
    check("arst.busy", bus.busy_o, 1'b0);
    check("arst.ready", bus.in_ready_o, 1'b1);
    last_data = '0;
    tick();
    rst_n = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 64'h1111_2222_3333_4444;
    tick();
    idle_inputs();
    check_quiet("arst.rvalid");
    check("arst.busy2", bus.busy_o, 1'b0);

    // Randomized mix.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0, 1: do_simple(2'($urandom_range(1, 3)), 5'($urandom), 1'($urandom),
                        {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
        2: begin
          int d;
          int fa;
          d  = $urandom_range(0, 5);
          fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, d)) : -1;
          do_load(3'($urandom), int'($urandom_range(0, 7)), {$urandom, $urandom},
                  5'($urandom), 1'($urandom), d, fa);
        end
        default: begin
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = {$urandom, $urandom};
          tick();
          idle_inputs();
          check_quiet("rand.gap");
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
